// File: rtl/branch_station.sv
// ---------------------------------------------------------------------------
// branch_station
//   In-order reservation station in front of the branch execution unit.
//   Entries are held in a circular FIFO; each entry waits for both source
//   operands (woken by the common data bus) and only the head may issue.
//
// Ports
//   clk_i, reset_i          clock, asynchronous active-high reset
//   flush_i                 branch-miss squash, empties the station
//   dispatch_*_i / _o       dispatch handshake plus branch fields and operands
//   cdb_valid_i/id_i/data_i result broadcast used for operand wakeup
//   issue_valid_o/ready_i   issue handshake toward the branch unit
//   issue_*_o               head entry contents (zero while empty)
// ---------------------------------------------------------------------------
module branch_station #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 6
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            flush_i,
  input  logic            dispatch_valid_i,
  output logic            dispatch_ready_o,
  input  logic [ID_W-1:0] dispatch_commit_id_i,
  input  logic [2:0]      dispatch_funct_i,
  input  logic            dispatch_jr_i,
  input  logic            dispatch_approx_i,
  input  logic [31:0]     dispatch_new_pc_i,
  input  logic            dispatch_src1_valid_i,
  input  logic [ID_W-1:0] dispatch_src1_tag_i,
  input  logic [31:0]     dispatch_src1_data_i,
  input  logic            dispatch_src2_valid_i,
  input  logic [ID_W-1:0] dispatch_src2_tag_i,
  input  logic [31:0]     dispatch_src2_data_i,
  input  logic            cdb_valid_i,
  input  logic [ID_W-1:0] cdb_id_i,
  input  logic [31:0]     cdb_data_i,
  output logic            issue_valid_o,
  input  logic            issue_ready_i,
  output logic [ID_W-1:0] issue_commit_id_o,
  output logic [2:0]      issue_funct_o,
  output logic            issue_jr_o,
  output logic            issue_approx_o,
  output logic [31:0]     issue_new_pc_o,
  output logic [31:0]     issue_src1_data_o,
  output logic [31:0]     issue_src2_data_o
);

  localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]  CNT_ONE  = (PTR_W + 1)'(1);

  // Pointer / occupancy state
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             dispatch_ready_q;

  // Entry storage
  logic            vld_q     [DEPTH];
  logic [ID_W-1:0] id_q      [DEPTH];
  logic [2:0]      funct_q   [DEPTH];
  logic            jr_q      [DEPTH];
  logic            approx_q  [DEPTH];
  logic [31:0]     pc_q      [DEPTH];
  logic            s1_rdy_q  [DEPTH];
  logic [ID_W-1:0] s1_tag_q  [DEPTH];
  logic [31:0]     s1_data_q [DEPTH];
  logic            s2_rdy_q  [DEPTH];
  logic [ID_W-1:0] s2_tag_q  [DEPTH];
  logic [31:0]     s2_data_q [DEPTH];

  logic        dispatch_fire;
  logic        pop_fire;
  logic        head_busy;
  logic        s1_rdy_in;
  logic        s2_rdy_in;
  logic [31:0] s1_data_in;
  logic [31:0] s2_data_in;

  // Handshake qualification and next-state pointer/count computation
  always_comb begin
    dispatch_fire = dispatch_valid_i && dispatch_ready_q && !flush_i;
    pop_fire      = issue_valid_o && issue_ready_i && !flush_i;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    if (flush_i) begin
      head_d  = {PTR_W{1'b0}};
      tail_d  = {PTR_W{1'b0}};
      count_d = {(PTR_W + 1){1'b0}};
    end else begin
      if (dispatch_fire) begin
        tail_d = tail_q + PTR_ONE;
      end else begin
        tail_d = tail_q;
      end
      if (pop_fire) begin
        head_d = head_q + PTR_ONE;
      end else begin
        head_d = head_q;
      end
      case ({dispatch_fire, pop_fire})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Operand capture at dispatch: a same-cycle CDB hit on a pending tag counts as ready
  always_comb begin
    s1_rdy_in  = 1'b0;
    s2_rdy_in  = 1'b0;
    s1_data_in = dispatch_src1_data_i;
    s2_data_in = dispatch_src2_data_i;
    if (dispatch_src1_valid_i) begin
      s1_rdy_in = 1'b1;
    end else if (cdb_valid_i && (dispatch_src1_tag_i == cdb_id_i)) begin
      s1_rdy_in  = 1'b1;
      s1_data_in = cdb_data_i;
    end else begin
      s1_rdy_in = 1'b0;
    end
    if (dispatch_src2_valid_i) begin
      s2_rdy_in = 1'b1;
    end else if (cdb_valid_i && (dispatch_src2_tag_i == cdb_id_i)) begin
      s2_rdy_in  = 1'b1;
      s2_data_in = cdb_data_i;
    end else begin
      s2_rdy_in = 1'b0;
    end
  end

  // Pointer, count and registered dispatch_ready update
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_q           <= {PTR_W{1'b0}};
      tail_q           <= {PTR_W{1'b0}};
      count_q          <= {(PTR_W + 1){1'b0}};
      dispatch_ready_q <= 1'b1;
    end else begin
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      // Registered, so a pop in the same cycle never makes a full station ready
      dispatch_ready_q <= (count_d != FULL_CNT);
    end
  end

  // Entry storage: CDB wakeup, pop invalidation, dispatch write (later wins)
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i]     <= 1'b0;
        id_q[i]      <= {ID_W{1'b0}};
        funct_q[i]   <= 3'd0;
        jr_q[i]      <= 1'b0;
        approx_q[i]  <= 1'b0;
        pc_q[i]      <= 32'd0;
        s1_rdy_q[i]  <= 1'b0;
        s1_tag_q[i]  <= {ID_W{1'b0}};
        s1_data_q[i] <= 32'd0;
        s2_rdy_q[i]  <= 1'b0;
        s2_tag_q[i]  <= {ID_W{1'b0}};
        s2_data_q[i] <= 32'd0;
      end
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i]    <= 1'b0;
        s1_rdy_q[i] <= 1'b0;
        s2_rdy_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        // Both sources are checked independently so they can wake together
        if (vld_q[i] && cdb_valid_i && !s1_rdy_q[i] && (s1_tag_q[i] == cdb_id_i)) begin
          s1_rdy_q[i]  <= 1'b1;
          s1_data_q[i] <= cdb_data_i;
        end
        if (vld_q[i] && cdb_valid_i && !s2_rdy_q[i] && (s2_tag_q[i] == cdb_id_i)) begin
          s2_rdy_q[i]  <= 1'b1;
          s2_data_q[i] <= cdb_data_i;
        end
        if (pop_fire && (PTR_W'(i) == head_q)) begin
          vld_q[i] <= 1'b0;
        end
        if (dispatch_fire && (PTR_W'(i) == tail_q)) begin
          vld_q[i]     <= 1'b1;
          id_q[i]      <= dispatch_commit_id_i;
          funct_q[i]   <= dispatch_funct_i;
          jr_q[i]      <= dispatch_jr_i;
          approx_q[i]  <= dispatch_approx_i;
          pc_q[i]      <= dispatch_new_pc_i;
          s1_rdy_q[i]  <= s1_rdy_in;
          s1_tag_q[i]  <= dispatch_src1_tag_i;
          s1_data_q[i] <= s1_data_in;
          s2_rdy_q[i]  <= s2_rdy_in;
          s2_tag_q[i]  <= dispatch_src2_tag_i;
          s2_data_q[i] <= s2_data_in;
        end
      end
    end
  end

  assign dispatch_ready_o = dispatch_ready_q;
  assign head_busy        = (count_q != {(PTR_W + 1){1'b0}});

  // Issue outputs come only from registered head contents, zero when empty
  always_comb begin
    issue_valid_o     = 1'b0;
    issue_commit_id_o = {ID_W{1'b0}};
    issue_funct_o     = 3'd0;
    issue_jr_o        = 1'b0;
    issue_approx_o    = 1'b0;
    issue_new_pc_o    = 32'd0;
    issue_src1_data_o = 32'd0;
    issue_src2_data_o = 32'd0;
    if (head_busy) begin
      issue_valid_o     = s1_rdy_q[head_q] && s2_rdy_q[head_q];
      issue_commit_id_o = id_q[head_q];
      issue_funct_o     = funct_q[head_q];
      issue_jr_o        = jr_q[head_q];
      issue_approx_o    = approx_q[head_q];
      issue_new_pc_o    = pc_q[head_q];
      issue_src1_data_o = s1_data_q[head_q];
      issue_src2_data_o = s2_data_q[head_q];
    end else begin
      issue_valid_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_station.sv
// ---------------------------------------------------------------------------
// tb_branch_station
//   Directed self-checking bench for branch_station (DEPTH=4, ID_W=6).
//   Expected issue transactions are queued when a dispatch is accepted and
//   compared field by field when the station issues them.
// ---------------------------------------------------------------------------
module tb_branch_station;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        dispatch_valid;
  logic        dispatch_ready;
  logic [5:0]  d_id;
  logic [2:0]  d_funct;
  logic        d_jr;
  logic        d_approx;
  logic [31:0] d_pc;
  logic        d_s1v;
  logic [5:0]  d_s1t;
  logic [31:0] d_s1d;
  logic        d_s2v;
  logic [5:0]  d_s2t;
  logic [31:0] d_s2d;
  logic        cdb_valid;
  logic [5:0]  cdb_id;
  logic [31:0] cdb_data;
  logic        issue_valid;
  logic        issue_ready;
  logic [5:0]  i_id;
  logic [2:0]  i_funct;
  logic        i_jr;
  logic        i_approx;
  logic [31:0] i_pc;
  logic [31:0] i_s1;
  logic [31:0] i_s2;

  typedef struct {
    logic [5:0]  id;
    logic [2:0]  funct;
    logic        jr;
    logic        approx;
    logic [31:0] pc;
    logic [31:0] s1;
    logic [31:0] s2;
  } exp_t;

  exp_t sb[$];
  exp_t pend;
  int   m_cnt    = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  branch_station #(.DEPTH(4), .ID_W(6)) dut (
    .clk_i                (clk),
    .reset_i              (reset),
    .flush_i              (flush),
    .dispatch_valid_i     (dispatch_valid),
    .dispatch_ready_o     (dispatch_ready),
    .dispatch_commit_id_i (d_id),
    .dispatch_funct_i     (d_funct),
    .dispatch_jr_i        (d_jr),
    .dispatch_approx_i    (d_approx),
    .dispatch_new_pc_i    (d_pc),
    .dispatch_src1_valid_i(d_s1v),
    .dispatch_src1_tag_i  (d_s1t),
    .dispatch_src1_data_i (d_s1d),
    .dispatch_src2_valid_i(d_s2v),
    .dispatch_src2_tag_i  (d_s2t),
    .dispatch_src2_data_i (d_s2d),
    .cdb_valid_i          (cdb_valid),
    .cdb_id_i             (cdb_id),
    .cdb_data_i           (cdb_data),
    .issue_valid_o        (issue_valid),
    .issue_ready_i        (issue_ready),
    .issue_commit_id_o    (i_id),
    .issue_funct_o        (i_funct),
    .issue_jr_o           (i_jr),
    .issue_approx_o       (i_approx),
    .issue_new_pc_o       (i_pc),
    .issue_src1_data_o    (i_s1),
    .issue_src2_data_o    (i_s2)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    dispatch_valid = 1'b0;
    cdb_valid = 1'b0;
    flush = 1'b0;
    d_id = 6'd0; d_funct = 3'd0; d_jr = 1'b0; d_approx = 1'b0; d_pc = 32'd0;
    d_s1v = 1'b0; d_s1t = 6'd0; d_s1d = 32'd0;
    d_s2v = 1'b0; d_s2t = 6'd0; d_s2d = 32'd0;
    cdb_id = 6'd0; cdb_data = 32'd0;
  endtask

  // Drive one dispatch; e1/e2 are the operand values the entry must issue with
  task automatic dispatch(input logic [5:0] id, input logic [2:0] funct, input logic jr,
                          input logic approx, input logic [31:0] pc,
                          input logic s1v, input logic [5:0] s1t, input logic [31:0] s1d,
                          input logic s2v, input logic [5:0] s2t, input logic [31:0] s2d,
                          input logic [31:0] e1, input logic [31:0] e2);
    dispatch_valid = 1'b1;
    d_id = id; d_funct = funct; d_jr = jr; d_approx = approx; d_pc = pc;
    d_s1v = s1v; d_s1t = s1t; d_s1d = s1d;
    d_s2v = s2v; d_s2t = s2t; d_s2d = s2d;
    pend.id = id; pend.funct = funct; pend.jr = jr; pend.approx = approx;
    pend.pc = pc; pend.s1 = e1; pend.s2 = e2;
  endtask

  task automatic cdb(input logic [5:0] id, input logic [31:0] data);
    cdb_valid = 1'b1;
    cdb_id = id;
    cdb_data = data;
  endtask

  // Handle handshakes before the edge against the model, then advance one cycle
  task automatic tick();
    exp_t e;
    logic accept;
    #1;
    chk1("dispatch_ready", dispatch_ready, (m_cnt < 4));
    accept = dispatch_valid && (m_cnt < 4);
    if (flush) begin
      sb.delete();
      m_cnt = 0;
    end else begin
      if (issue_valid && issue_ready) begin
        if (sb.size() == 0) begin
          chk1("issue_valid_empty", issue_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          m_cnt--;
          chk32("pop_id", {26'd0, i_id}, {26'd0, e.id});
          chk32("pop_funct", {29'd0, i_funct}, {29'd0, e.funct});
          chk1("pop_jr", i_jr, e.jr);
          chk1("pop_approx", i_approx, e.approx);
          chk32("pop_pc", i_pc, e.pc);
          chk32("pop_src1", i_s1, e.s1);
          chk32("pop_src2", i_s2, e.s2);
        end
      end
      if (accept) begin
        sb.push_back(pend);
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    dispatch_valid = 1'b0;
    cdb_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic chk_empty_outputs(input string tag);
    chk1({tag, "_issue_valid"}, issue_valid, 1'b0);
    chk32({tag, "_issue_id"}, {26'd0, i_id}, 32'd0);
    chk32({tag, "_issue_pc"}, i_pc, 32'd0);
    chk32({tag, "_issue_src1"}, i_s1, 32'd0);
  endtask

  initial begin
    drive_idle();
    issue_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk1("rst_dispatch_ready", dispatch_ready, 1'b1);
    chk_empty_outputs("rst");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Both operands ready: issues next cycle, then empties
    issue_ready = 1'b1;
    dispatch(6'd3, 3'd0, 1'b0, 1'b1, 32'h100, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd5, 32'd5, 32'd5);
    tick();
    chk1("t28_issue_valid", issue_valid, 1'b1);
    chk32("t28_id", {26'd0, i_id}, 32'd3);
    chk32("t28_src1", i_s1, 32'd5);
    chk32("t28_src2", i_s2, 32'd5);
    chk32("t28_pc", i_pc, 32'h100);
    tick();
    chk_empty_outputs("t28_after");

    // Pending src1 woken by CDB two cycles after dispatch
    dispatch(6'd4, 3'd2, 1'b1, 1'b0, 32'h200, 1'b0, 6'd9, 32'd0, 1'b1, 6'd0, 32'd1, 32'h2A, 32'd1);
    tick();
    chk1("t29_wait0", issue_valid, 1'b0);
    tick();
    chk1("t29_wait1", issue_valid, 1'b0);
    cdb(6'd9, 32'h2A);
    tick();
    chk1("t29_woken", issue_valid, 1'b1);
    chk32("t29_src1", i_s1, 32'h2A);
    tick();

    // CDB hit in the dispatch cycle stores the operand ready
    dispatch(6'd5, 3'd1, 1'b0, 1'b0, 32'h300, 1'b1, 6'd0, 32'h11, 1'b0, 6'd7, 32'd0, 32'h11, 32'hFFFF_FFFF);
    cdb(6'd7, 32'hFFFF_FFFF);
    tick();
    chk1("t30_issue_valid", issue_valid, 1'b1);
    chk32("t30_src2", i_s2, 32'hFFFF_FFFF);
    tick();

    // Fill to full with issue blocked, reject a fifth, then drain in order
    issue_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      dispatch(6'd10 + 6'(k), 3'(k), 1'b0, 1'b0, 32'h400 + 32'(k), 1'b1, 6'd0, 32'(k),
               1'b1, 6'd0, 32'(k + 100), 32'(k), 32'(k + 100));
      tick();
    end
    chk1("t31_full_not_ready", dispatch_ready, 1'b0);
    chk1("t31_hold_valid", issue_valid, 1'b1);
    chk32("t31_hold_id", {26'd0, i_id}, 32'd10);
    dispatch(6'd14, 3'd7, 1'b0, 1'b0, 32'h4FF, 1'b1, 6'd0, 32'd9, 1'b1, 6'd0, 32'd9, 32'd9, 32'd9);
    tick();
    chk32("t31_hold_id2", {26'd0, i_id}, 32'd10);
    issue_ready = 1'b1;
    repeat (4) tick();
    chk_empty_outputs("t31_drained");
    // Back-to-back dispatch with concurrent pops wraps the pointers
    for (int k = 0; k < 5; k++) begin
      dispatch(6'd50 + 6'(k), 3'd3, 1'b1, 1'b1, 32'h500 + 32'(k), 1'b1, 6'd0, 32'(k + 7),
               1'b1, 6'd0, 32'(k + 8), 32'(k + 7), 32'(k + 8));
      tick();
    end
    tick();

    // Non-ready head blocks a ready younger entry
    dispatch(6'd20, 3'd4, 1'b0, 1'b0, 32'h600, 1'b0, 6'd12, 32'd0, 1'b1, 6'd0, 32'd3, 32'h55, 32'd3);
    tick();
    dispatch(6'd21, 3'd5, 1'b0, 1'b0, 32'h604, 1'b1, 6'd0, 32'd6, 1'b1, 6'd0, 32'd6, 32'd6, 32'd6);
    tick();
    chk1("t32_blocked0", issue_valid, 1'b0);
    tick();
    chk1("t32_blocked1", issue_valid, 1'b0);
    cdb(6'd12, 32'h55);
    tick();
    chk1("t32_head_woken", issue_valid, 1'b1);
    chk32("t32_head_id", {26'd0, i_id}, 32'd20);
    tick();
    tick();
    // Both operands of one entry woken by the same broadcast
    dispatch(6'd22, 3'd6, 1'b0, 1'b1, 32'h700, 1'b0, 6'd15, 32'd0, 1'b0, 6'd15, 32'd0, 32'h77, 32'h77);
    tick();
    chk1("t16_wait", issue_valid, 1'b0);
    cdb(6'd15, 32'h77);
    tick();
    chk32("t16_src1", i_s1, 32'h77);
    chk32("t16_src2", i_s2, 32'h77);
    tick();

    // Flush with a concurrent dispatch discards everything
    issue_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      dispatch(6'd30 + 6'(k), 3'd0, 1'b0, 1'b0, 32'h800, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd2, 32'd1, 32'd2);
      tick();
    end
    dispatch(6'd33, 3'd0, 1'b0, 1'b0, 32'h8FF, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd2, 32'd1, 32'd2);
    flush = 1'b1;
    tick();
    chk_empty_outputs("t33_flushed");
    issue_ready = 1'b1;
    dispatch(6'd34, 3'd1, 1'b0, 1'b0, 32'h900, 1'b1, 6'd0, 32'hA, 1'b1, 6'd0, 32'hB, 32'hA, 32'hB);
    tick();
    chk32("t33_next_id", {26'd0, i_id}, 32'd34);
    tick();

    // Asynchronous reset mid-operation
    issue_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      dispatch(6'd40 + 6'(k), 3'd0, 1'b0, 1'b0, 32'hA00, 1'b1, 6'd0, 32'd4, 1'b1, 6'd0, 32'd4, 32'd4, 32'd4);
      tick();
    end
    #2;
    reset = 1'b1;
    #1;
    chk1("rst_async_ready", dispatch_ready, 1'b1);
    chk_empty_outputs("rst_async");
    sb.delete();
    m_cnt = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    issue_ready = 1'b1;
    dispatch(6'd45, 3'd2, 1'b1, 1'b1, 32'hB00, 1'b1, 6'd0, 32'hC, 1'b1, 6'd0, 32'hD, 32'hC, 32'hD);
    tick();
    chk32("rst_first_id", {26'd0, i_id}, 32'd45);

    // Bounded drain of anything still expected
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
    chk32("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/branch_station.md
BRANCH_STATION -- requirements
Module: branch_station

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of entries (power of two, 2..16).
REQ-002 Parameter ID_W, default 6, SHALL set the commit-id and tag width.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high; SHALL clear state immediately on assertion.
REQ-005 flush  in  1  branch-miss squash; SHALL discard all entries.
REQ-006 dispatch_valid  in  1 / dispatch_ready  out  1  dispatch handshake.
REQ-007 dispatch_commit_id  in  ID_W; dispatch_funct  in  3; dispatch_jr  in  1; dispatch_approx  in  1 (predicted taken); dispatch_new_pc  in  32  branch fields.
REQ-008 dispatch_srcN_valid  in  1; dispatch_srcN_tag  in  ID_W; dispatch_srcN_data  in  32, for N=1,2; data SHALL be meaningful only when valid=1, and tag only when valid=0.
REQ-009 cdb_valid  in  1; cdb_id  in  ID_W; cdb_data  in  32  result broadcast used for operand wakeup.
REQ-010 issue_valid  out  1 / issue_ready  in  1  issue handshake toward the branch execution unit.
REQ-011 issue_commit_id  out  ID_W; issue_funct  out  3; issue_jr  out  1; issue_approx  out  1; issue_new_pc  out  32; issue_src1_data  out  32; issue_src2_data  out  32.

Function
REQ-012 Storage SHALL be a circular FIFO with head and tail pointers (log2 DEPTH bits, wrap modulo DEPTH) and a count of 0..DEPTH.
REQ-013 dispatch_ready SHALL equal (count < DEPTH) and SHALL be driven from registered state only; a same-cycle pop SHALL NOT make a full station ready.
REQ-014 Dispatch SHALL occur when dispatch_valid && dispatch_ready && !flush; the entry SHALL be written at tail and tail SHALL advance by 1.
REQ-015 Each entry SHALL hold, per source, a ready bit, a tag, and 32-bit data.
REQ-016 Every cycle with cdb_valid=1, each valid entry whose not-ready source tag equals cdb_id SHALL capture cdb_data and set its ready bit; both sources of one entry SHALL be able to wake in the same cycle.
REQ-017 On dispatch, a source with valid=0 whose tag equals cdb_id while cdb_valid=1 SHALL be stored ready with cdb_data; otherwise it SHALL store valid/tag/data as given.
REQ-018 Issue SHALL be in order from head only: issue_valid = (count>0) && head.src1_ready && head.src2_ready.
REQ-019 issue_* outputs SHALL be driven from the head entry's registered contents; they SHALL be zero when count=0.
REQ-020 A pop SHALL occur when issue_valid && issue_ready && !flush; head SHALL advance by 1.
REQ-021 Simultaneous dispatch and pop SHALL leave count unchanged.
REQ-022 Latency: a dispatch with both sources valid into an empty station SHALL raise issue_valid on the next cycle; a CDB wakeup of the head's last missing operand SHALL raise issue_valid on the next cycle; there SHALL be no combinational dispatch-to-issue or CDB-to-issue path.
REQ-023 issue_valid, once asserted, SHALL hold with stable outputs until popped or flushed.
REQ-024 flush=1 SHALL set count, head, and tail to 0 on the next edge; dispatch, pop, and wakeup in that cycle SHALL be ignored.
REQ-025 Younger entries SHALL NOT issue ahead of a non-ready head.

Reset
REQ-026 While reset=1: count=0, head=tail=0, all entry ready bits=0, issue_valid=0, issue_* =0, dispatch_ready=1.
REQ-027 Reset asserted mid-operation SHALL discard all entries; the first dispatch after deassertion SHALL land in entry 0.

Verification
REQ-028 Dispatch {id=3, funct=0, src1=5 valid, src2=5 valid, new_pc=0x100}, issue_ready=1 -> issue_valid=1 next cycle with src1=src2=5 and commit_id=3; count returns to 0 the cycle after.
REQ-029 Dispatch id=4 with src1 tag=9 not ready; cdb {id=9, data=0x2A} two cycles later -> issue_valid=0 until the cycle after the CDB, then issue_src1_data=0x2A.
REQ-030 Dispatch with src2 tag=7 not ready while cdb {id=7, data=0xFFFF_FFFF} in the same cycle -> entry stored ready; issue_valid next cycle with src2=0xFFFF_FFFF.
REQ-031 issue_ready=0, dispatch 4 ready entries -> dispatch_ready=0 after the 4th; a 5th dispatch is not accepted; then issue_ready=1 -> ids pop in dispatch order, and tail wraps to 0 on the next dispatch.
REQ-032 Head not ready, entry 2 ready -> issue_valid stays 0 until head wakes (no bypass ordering).
REQ-033 Three entries queued, flush=1 concurrent with dispatch_valid=1 -> next cycle count=0, issue_valid=0, dispatch_ready=1, and the flushed dispatch is absent.
